// File: rtl/io_ctrl.sv
// -----------------------------------------------------------------------------
// io_ctrl
//
// Memory-mapped I/O controller that sits beside the data memory on the
// processor bus. It exposes a window of NCH data channels and three interrupt
// control registers. It also raises an interrupt request when it detects an
// edge on bit 0 of any channel input.
//
// Register map (word offsets from BASE):
//   0      PENDING   NCH bits, read / write-1-to-clear
//   1      MASK      NCH bits, read / write
//   2      EDGE_SEL  NCH bits, read / write (1 = rising, 0 = falling)
//   3      reserved  reads 0, writes ignored
//   4+i    channel i read: synchronised entrada[i]; write: saida[i]
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   address    processor word address (NBITS-2 bits)
//   wdata      processor write data
//   wren       processor write strobe
//   sel        combinational; address lies inside the register window
//   sel_q      sel delayed one cycle; steers the top-level read mux
//   rdata      registered read data, one cycle after the address
//   entrada    asynchronous channel inputs, channel i at [i*NBITS +: NBITS]
//   saida      registered channel outputs, same packing as entrada
//   interrupt  registered |(PENDING & MASK)
// -----------------------------------------------------------------------------
module io_ctrl #(
    parameter int NBITS   = 8,
    parameter int NCH     = 4,
    parameter int BASE    = 'h38,
    parameter int ARM_CYC = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NBITS-3:0]     address,
    input  logic [NBITS-1:0]     wdata,
    input  logic                 wren,
    output logic                 sel,
    output logic                 sel_q,
    output logic [NBITS-1:0]     rdata,
    input  logic [NCH*NBITS-1:0] entrada,
    output logic [NCH*NBITS-1:0] saida,
    output logic                 interrupt
);

    localparam int AW    = NBITS - 2;
    localparam int NREG  = 4 + NCH;
    localparam int ARM_W = (ARM_CYC < 1) ? 1 : $clog2(ARM_CYC + 1);

    localparam logic [AW-1:0] BASE_A   = AW'(BASE);
    localparam logic [AW-1:0] LAST_A   = AW'(BASE + NREG - 1);
    localparam logic [AW-1:0] OFF_PEND = AW'(0);
    localparam logic [AW-1:0] OFF_MASK = AW'(1);
    localparam logic [AW-1:0] OFF_EDGE = AW'(2);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NCH*NBITS-1:0] sync1_reg;
    logic [NCH*NBITS-1:0] sync2_reg;
    logic [NCH-1:0]       hist_reg;
    logic [ARM_W-1:0]     arm_reg;
    logic [NCH-1:0]       pending_reg;
    logic [NCH-1:0]       mask_reg;
    logic [NCH-1:0]       edge_sel_reg;
    logic [NCH*NBITS-1:0] saida_reg;
    logic [NBITS-1:0]     rdata_reg;
    logic                 sel_q_reg;
    logic                 interrupt_reg;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [AW-1:0]    offset;
    logic             wr_hit;
    logic             wr_pend;
    logic             wr_mask;
    logic             wr_edge;
    logic [NCH-1:0]   wr_ch;
    logic [NCH-1:0]   wr_field;
    logic [NCH-1:0]   ch_bit0;
    logic [NCH-1:0]   rise_evt;
    logic [NCH-1:0]   fall_evt;
    logic [NCH-1:0]   evt;
    logic             armed;
    logic [NCH-1:0]   w1c_bits;
    logic [NCH-1:0]   pending_next;
    logic [NCH-1:0]   mask_next;
    logic [NBITS-1:0] rd_value;
    logic [NBITS-1:0] rdata_next;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    assign sel    = (address >= BASE_A) && (address <= LAST_A);
    assign offset = address - BASE_A;

    // A write only lands when the strobe coincides with a window hit.
    assign wr_hit   = wren & sel;
    assign wr_pend  = wr_hit && (offset == OFF_PEND);
    assign wr_mask  = wr_hit && (offset == OFF_MASK);
    assign wr_edge  = wr_hit && (offset == OFF_EDGE);
    assign wr_field = wdata[NCH-1:0];

    // -------------------------------------------------------------------------
    // Per-channel decode and edge detection
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign wr_ch[gi]    = wr_hit && (offset == AW'(4 + gi));
            assign ch_bit0[gi]  = sync2_reg[gi*NBITS];
            assign rise_evt[gi] =  ch_bit0[gi] & ~hist_reg[gi];
            assign fall_evt[gi] = ~ch_bit0[gi] &  hist_reg[gi];
            // Events only count once the arm counter has expired, so input
            // levels present during reset never look like edges.
            assign evt[gi] = armed & (edge_sel_reg[gi] ? rise_evt[gi] : fall_evt[gi]);
        end
    endgenerate

    assign armed = (arm_reg == '0);

    // -------------------------------------------------------------------------
    // Next-state for PENDING / MASK. A simultaneous set and W1C on the same
    // bit resolves to set, so no event is ever lost.
    // -------------------------------------------------------------------------
    assign w1c_bits     = wr_pend ? wr_field : '0;
    assign pending_next = (pending_reg & ~w1c_bits) | evt;
    assign mask_next    = wr_mask ? wr_field : mask_reg;

    // -------------------------------------------------------------------------
    // Read mux. Reads sample the current register contents, so a read of an
    // address being written in the same cycle returns the old value.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_value = '0;
        if (offset == OFF_PEND) begin
            rd_value[NCH-1:0] = pending_reg;
        end else if (offset == OFF_MASK) begin
            rd_value[NCH-1:0] = mask_reg;
        end else if (offset == OFF_EDGE) begin
            rd_value[NCH-1:0] = edge_sel_reg;
        end
        for (int i = 0; i < NCH; i++) begin
            if (offset == AW'(4 + i)) begin
                rd_value = sync2_reg[i*NBITS +: NBITS];
            end
        end
        rdata_next = sel ? rd_value : '0;
    end

    // -------------------------------------------------------------------------
    // Input synchroniser and edge history
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            hist_reg  <= '0;
        end else begin
            sync1_reg <= entrada;
            sync2_reg <= sync1_reg;
            // History keeps tracking while disarmed so the first armed cycle
            // compares against a settled value.
            hist_reg  <= ch_bit0;
        end
    end

    // -------------------------------------------------------------------------
    // Arm counter: counts down from ARM_CYC after reset release, then holds 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arm_reg <= ARM_W'(ARM_CYC);
        end else if (!armed) begin
            arm_reg <= arm_reg - ARM_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Control registers and interrupt
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_reg   <= '0;
            mask_reg      <= '0;
            edge_sel_reg  <= '1;
            interrupt_reg <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            mask_reg      <= mask_next;
            if (wr_edge) begin
                edge_sel_reg <= wr_field;
            end
            // Built from next-state values so the output always matches
            // the registered PENDING & MASK in the same cycle.
            interrupt_reg <= |(pending_next & mask_next);
        end
    end

    // -------------------------------------------------------------------------
    // Channel outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saida_reg <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ch[i]) begin
                    saida_reg[i*NBITS +: NBITS] <= wdata;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read data pipeline, one cycle like the neighbouring memory
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_reg <= '0;
            sel_q_reg <= 1'b0;
        end else begin
            rdata_reg <= rdata_next;
            sel_q_reg <= sel;
        end
    end

    assign sel_q     = sel_q_reg;
    assign rdata     = rdata_reg;
    assign saida     = saida_reg;
    assign interrupt = interrupt_reg;

endmodule

// File: tb/tb_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_ctrl
//
// Directed, self-checking bench for io_ctrl (NBITS=8, NCH=4, BASE='h38,
// ARM_CYC=3). Reads push their expected data onto a scoreboard queue when the
// address is presented and are popped and compared after the next clock edge.
// -----------------------------------------------------------------------------
module tb_io_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  address;
    logic [7:0]  wdata;
    logic        wren;
    logic        sel;
    logic        sel_q;
    logic [7:0]  rdata;
    logic [31:0] entrada;
    logic [31:0] saida;
    logic        interrupt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       sq;
    } exp_t;

    exp_t sb[$];

    io_ctrl #(
        .NBITS   (8),
        .NCH     (4),
        .BASE    ('h38),
        .ARM_CYC (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .wdata     (wdata),
        .wren      (wren),
        .sel       (sel),
        .sel_q     (sel_q),
        .rdata     (rdata),
        .entrada   (entrada),
        .saida     (saida),
        .interrupt (interrupt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present a read, queue its expectation, clock once, then retire it.
    task automatic rd(input logic [5:0] a, input logic [7:0] e, input string tag);
        exp_t x;
        logic in_win;
        in_win  = (a >= 6'h38);
        address = a;
        wren    = 1'b0;
        #1;
        chk({tag, "_sel"}, 32'(sel), 32'(in_win));
        x.tag  = tag;
        x.data = e;
        x.sq   = in_win;
        sb.push_back(x);
        tick();
        x = sb.pop_front();
        chk(x.tag, 32'(rdata), 32'(x.data));
        chk({x.tag, "_selq"}, 32'(sel_q), 32'(x.sq));
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        address = a;
        wdata   = d;
        wren    = 1'b1;
        tick();
        wren    = 1'b0;
        wdata   = 8'h00;
        $display("write addr=%0h data=%0h", a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        address = 6'h00;
        wdata   = 8'h00;
        wren    = 1'b0;
        entrada = 32'hFFFF_FFFF;

        // ---------------- reset / arming ----------------
        tick();
        tick();
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_selq", 32'(sel_q), 32'h0);
        chk("rst_int", 32'(interrupt), 32'h0);
        chk("rst_saida", saida, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rd(6'h38, 8'h00, "arm_pend");
        rd(6'h3A, 8'h0F, "arm_edge");
        rd(6'h39, 8'h00, "arm_mask");
        rd(6'h3B, 8'h00, "arm_rsv");
        rd(6'h3C, 8'hFF, "arm_ch0");
        rd(6'h3F, 8'hFF, "arm_ch3");
        rd(6'h37, 8'h00, "below_win");
        chk("arm_int", 32'(interrupt), 32'h0);
        chk("arm_saida", saida, 32'h0);

        // ---------------- output write / readback ----------------
        wr(6'h3D, 8'hA5);
        chk("wr_ch1_saida", saida, 32'h0000_A500);
        address = 6'h20;
        #1;
        chk("out_win_sel", 32'(sel), 32'h0);
        wr(6'h20, 8'h11);
        chk("out_win_saida", saida, 32'h0000_A500);
        rd(6'h39, 8'h00, "out_win_mask");
        rd(6'h3A, 8'h0F, "out_win_edge");
        rd(6'h38, 8'h00, "out_win_pend");
        rd(6'h20, 8'h00, "out_win_rd");
        wr(6'h3B, 8'hFF);
        rd(6'h3B, 8'h00, "rsv_rd");

        // ---------------- input read latency ----------------
        entrada[23:16] = 8'h3C;
        rd(6'h3E, 8'hFF, "lat_e1");
        rd(6'h3E, 8'hFF, "lat_e2");
        rd(6'h3E, 8'h3C, "lat_e3");

        // ---------------- rising interrupt ----------------
        wr(6'h39, 8'h01);
        entrada[7:0] = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        chk("ch0_fall_ignored_int", 32'(interrupt), 32'h0);
        rd(6'h38, 8'h00, "ch0_fall_ignored_pend");
        entrada[7:0] = 8'h01;
        tick();
        tick();
        chk("rise_int_early", 32'(interrupt), 32'h0);
        tick();
        chk("rise_int", 32'(interrupt), 32'h1);
        rd(6'h38, 8'h01, "rise_pend");
        wr(6'h38, 8'h01);
        chk("w1c_int", 32'(interrupt), 32'h0);
        rd(6'h38, 8'h00, "w1c_pend");

        // ---------------- falling edge + set wins ----------------
        wr(6'h3A, 8'h0C);
        wr(6'h39, 8'h03);
        entrada[15:8] = 8'h00;
        tick();
        tick();
        // W1C on bit 1 in the very cycle the falling event is detected.
        address = 6'h38;
        wdata   = 8'h02;
        wren    = 1'b1;
        tick();
        wren    = 1'b0;
        wdata   = 8'h00;
        chk("setwins_int", 32'(interrupt), 32'h1);
        rd(6'h38, 8'h02, "setwins_pend");
        wr(6'h38, 8'h02);
        chk("clr1_int", 32'(interrupt), 32'h0);
        rd(6'h38, 8'h00, "clr1_pend");
        entrada[7:0] = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        chk("ch0_fall_int", 32'(interrupt), 32'h1);
        rd(6'h38, 8'h01, "ch0_fall_pend");
        wr(6'h38, 8'h01);
        rd(6'h38, 8'h00, "ch0_fall_clr");
        entrada[7:0] = 8'h01;
        for (int i = 0; i < 4; i++) tick();
        chk("ch0_rise_ignored_int", 32'(interrupt), 32'h0);
        rd(6'h38, 8'h00, "ch0_rise_ignored_pend");

        // ---------------- mask gating / async reset ----------------
        wr(6'h39, 8'h00);
        entrada[23:16] = 8'h3D;
        for (int i = 0; i < 4; i++) tick();
        chk("masked_int", 32'(interrupt), 32'h0);
        rd(6'h38, 8'h04, "masked_pend");
        wr(6'h39, 8'h04);
        chk("unmask_int", 32'(interrupt), 32'h1);
        wr(6'h39, 8'h00);
        chk("remask_int", 32'(interrupt), 32'h0);
        rd(6'h38, 8'h04, "remask_pend");
        wr(6'h39, 8'h04);
        chk("unmask2_int", 32'(interrupt), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_int", 32'(interrupt), 32'h0);
        chk("async_saida", saida, 32'h0);
        chk("async_rdata", 32'(rdata), 32'h0);
        chk("async_selq", 32'(sel_q), 32'h0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rd(6'h38, 8'h00, "post_rst_pend");
        rd(6'h39, 8'h00, "post_rst_mask");
        rd(6'h3A, 8'h0F, "post_rst_edge");
        chk("post_rst_int", 32'(interrupt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
